vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Frame-buffer access scheduler for the VGA driver. It shares one single-port pixel RAM between the display path and a host writer. Display prefetch into a small pixel FIFO always has priority; host writes use the remaining cycles. It sits between the sync timing generator (which supplies `FRAME_START`/`DE`) and the RAM, and delivers one pixel per `PIX_CLK` while `DE` is high.

## Interface
- `ADDR_W`, 19: RAM address width.
- `DATA_W`, 8: pixel width.
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, ≥4.
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines; `H_ACTIVE*V_ACTIVE` ≤ 2^`ADDR_W`.
- `PIX_CLK` in 1: pixel clock; the only clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `FRAME_START` in 1: one-cycle pulse before the first visible pixel of a frame.
- `DE` in 1: display enable; one pixel is consumed per cycle while high.
- `PIX_DATA` out `DATA_W`: registered pixel output.
- `UNDERFLOW` out 1: sticky; FIFO was empty when `DE` was high.
- `HOST_VALID` in 1: host write request.
- `HOST_ADDR` in `ADDR_W`: host write address.
- `HOST_DATA` in `DATA_W`: host write data.
- `HOST_READY` out 1: host slot available this cycle.
- `MEM_ADDR` out `ADDR_W`: registered RAM address.
- `MEM_WE` out 1: registered RAM write enable.
- `MEM_WDATA` out `DATA_W`: registered RAM write data.
- `MEM_RDATA` in `DATA_W`: RAM read data, valid the cycle after `MEM_ADDR` is sampled.

## Operation
- States:
  - IDLE (reset state): no display fetches.
  - RUN: prefetching.
  - DONE: all `H_ACTIVE*V_ACTIVE` addresses for the frame have been issued.
- Transitions:
  - `FRAME_START` moves any state to RUN, sets `fetch_addr` to 0, flushes the FIFO and squashes all in-flight reads.
  - RUN moves to DONE in the cycle the read of address `H_ACTIVE*V_ACTIVE-1` is issued.
- `fetch_now` = (state==RUN) && (fifo_count + inflight < `FIFO_DEPTH`). When true, a read of `fetch_addr` is issued and `fetch_addr` increments.
- `HOST_READY` = `RST_N` && !`fetch_now`. It never depends on `HOST_VALID`.
- A host transfer happens on any edge where `HOST_VALID`&&`HOST_READY`. The next cycle drives `MEM_WE`=1 with the host address and data.
- Idle cycles (no fetch, no host transfer): `MEM_WE`=0 and `MEM_ADDR` holds its last value.
- Read return data is pushed into the FIFO two edges after issue. The in-flight count (at most 2) is tracked with a valid shift pipe. `FRAME_START` clears this pipe.
- Pixel output:
  - Each edge with `DE`=1 and the FIFO non-empty pops the FIFO and registers the head into `PIX_DATA`.
  - `DE`=1 with the FIFO empty gives `PIX_DATA`←0 and `UNDERFLOW`←1.
  - `DE`=0 gives `PIX_DATA`←0.
- Simultaneous push and pop in one cycle: count is unchanged.
- `FRAME_START` together with `DE`: `FRAME_START` wins; no pop and `PIX_DATA`←0.
- `UNDERFLOW` clears only on reset.

## Timing
- Reset values: `PIX_DATA`=0, `UNDERFLOW`=0, `MEM_ADDR`=0, `MEM_WE`=0, `MEM_WDATA`=0. `HOST_READY`=0 while `RST_N` is low.
- After reset and before the first `FRAME_START`, `HOST_READY`=1.
- Fetch latency: issue at edge k, FIFO push at edge k+2, earliest `PIX_DATA` at edge k+3.
- After `FRAME_START`, the FIFO is full after `FIFO_DEPTH`+2 cycles with `DE`=0. `DE` must not rise earlier, or `UNDERFLOW` sets.
- Steady state with `DE`=1: one fetch per cycle and host starved. Host writes proceed during blanking and in DONE.
- Host write appears on the RAM pins one cycle after acceptance.
- Reset mid-operation: all state is cleared immediately, in-flight reads are dropped, and the block returns to IDLE.

## Configuration
- `VGA_ARB_UNDERFLOW_CNT_EN` defined:
  - Adds output `UNDERFLOW_CNT` (16 bits), which increments on every underflowing `DE` cycle.
  - It saturates at 0xFFFF and resets to 0.
  - `UNDERFLOW` behaves as above.
- Undefined: the port and counter are absent.

## Test plan
All scenarios use `H_ACTIVE`=4, `V_ACTIVE`=2, `FIFO_DEPTH`=4, and RAM preloaded with addr→data = addr+0x10.
- Prefetch: pulse `FRAME_START`, wait 6 cycles → reads of addresses 0..3 issued, FIFO full, `HOST_READY`=1, no fetch of address 4 until a pop.
- Display: after the fill, hold `DE` high for 8 cycles → `PIX_DATA` = 0x10..0x17 on consecutive cycles, state DONE, `UNDERFLOW`=0.
- Early `DE`: raise `DE` 1 cycle after `FRAME_START` → `PIX_DATA`=0 and `UNDERFLOW`=1, sticky through frame end.
- Host write in DONE: `HOST_VALID`=1, addr 5, data 0xAB → `HOST_READY`=1, next cycle `MEM_WE`=1, `MEM_ADDR`=5, `MEM_WDATA`=0xAB; the next frame shows 0xAB at pixel 5.
- Host vs fetch: `HOST_VALID` held during fill → `HOST_READY`=0 on every fetch cycle, write accepted on the first non-fetch cycle, no lost or duplicated write.
- Restart: `FRAME_START` with 2 reads in flight, then async reset mid-fill → stale data never reaches `PIX_DATA`; after reset all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port pixel RAM between display prefetch (priority) and host writes.
// Define VGA_ARB_UNDERFLOW_CNT_EN to add a saturating 16-bit underflow_cnt output.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic              pix_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              de,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
  output logic [15:0]       underflow_cnt,
`endif
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        inflight;
  logic              fetch_now, host_xfer, push, pop, starve;
  // Reserve FIFO room for reads still in the RAM pipe so a push never overflows.
  always_comb begin
    fetch_now  = state == RUN && count + CW'(inflight[0]) + CW'(inflight[1]) < CW'(FIFO_DEPTH);
    host_ready = rst_n && !fetch_now;
    host_xfer  = host_valid && host_ready;
    push       = inflight[1] && !frame_start;
    pop        = de && count != '0 && !frame_start;
    starve     = de && count == '0 && !frame_start;
  end
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pix_data   <= '0;
      underflow  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      inflight <= {inflight[0] && !frame_start, fetch_now && !frame_start};
      if (frame_start) begin
        state      <= RUN;
        fetch_addr <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (fetch_now) begin
          fetch_addr <= fetch_addr + ADDR_W'(1);
          if (fetch_addr == LAST) state <= DONE;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      pix_data  <= pop ? fifo[rd_ptr] : '0;
      underflow <= underflow || starve;
      mem_we    <= host_xfer;
      if (fetch_now || host_xfer) mem_addr <= fetch_now ? fetch_addr : host_addr;
      if (host_xfer) mem_wdata <= host_data;
    end
  end
  always_ff @(posedge pix_clk)
    if (push) fifo[wr_ptr] <= mem_rdata;
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) underflow_cnt <= '0;
    else if (starve && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter with a 4x2 frame and a synchronous RAM model.
module tb_vga_fb_arbiter;
  logic       pix_clk = 1'b0;
  logic       rst_n, frame_start, de, host_valid, host_ready, underflow, mem_we;
  logic [3:0] host_addr, mem_addr;
  logic [7:0] host_data, pix_data, mem_wdata, mem_rdata;
  logic [7:0] ram [16];
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif
  int tests = 0;
  int fails = 0;

  always #5 pix_clk = ~pix_clk;

  vga_fb_arbiter #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4), .H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .pix_clk(pix_clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .de(de),
    .pix_data(pix_data),
    .underflow(underflow),
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .host_valid(host_valid),
    .host_addr(host_addr),
    .host_data(host_data),
    .host_ready(host_ready),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge pix_clk) begin
    if (!rst_n) for (int i = 0; i < 16; i++) ram[i] <= 8'(i + 16);
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(negedge pix_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; de = 1'b0; host_valid = 1'b0; host_addr = '0; host_data = '0;
    repeat (3) tick();
    check("rst_pix", pix_data, 0);
    check("rst_underflow", underflow, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", host_ready, 0);
    rst_n = 1'b1; #1;
    check("idle_ready", host_ready, 1);
    tick();
    check("idle_no_fetch", mem_addr, 0);
    // prefetch fill
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check("fill_ready", host_ready, i >= 5);
      if (i >= 2) check("fill_addr", mem_addr, (i - 2 > 3) ? 3 : i - 2);
      if (i < 7) tick();
    end
    de = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("disp_pix", pix_data, 'h10 + j);
    end
    de = 1'b0; tick();
    check("disp_end_pix", pix_data, 0);
    check("disp_underflow", underflow, 0);
    check("done_ready", host_ready, 1);
    check("done_last_addr", mem_addr, 7);
    // host write in DONE
    host_valid = 1'b1; host_addr = 4'd5; host_data = 8'hAB; #1;
    check("hw_ready", host_ready, 1);
    tick(); host_valid = 1'b0;
    check("hw_we", mem_we, 1);
    check("hw_addr", mem_addr, 5);
    check("hw_wdata", mem_wdata, 'hAB);
    tick();
    check("hw_we_drop", mem_we, 0);
    check("hw_addr_hold", mem_addr, 5);
    // host vs fetch during fill
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    host_valid = 1'b1; host_addr = 4'd12; host_data = 8'h5C;
    for (int i = 1; i <= 5; i++) begin
      check("hvf_ready", host_ready, i == 5);
      check("hvf_we_idle", mem_we, 0);
      tick();
    end
    host_valid = 1'b0;
    check("hvf_we", mem_we, 1);
    check("hvf_addr", mem_addr, 12);
    check("hvf_wdata", mem_wdata, 'h5C);
    tick();
    check("hvf_no_dup", mem_we, 0);
    check("hvf_addr_hold", mem_addr, 12);
    de = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("frame2_pix", pix_data, (j == 5) ? 'hAB : 'h10 + j);
    end
    de = 1'b0; tick();
    check("frame2_underflow", underflow, 0);
    // early DE
    frame_start = 1'b1; tick(); frame_start = 1'b0; de = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("early_pix", pix_data, (t < 4 || t == 12) ? 0 : ((t == 9) ? 'hAB : 'h10 + t - 4));
      check("early_underflow", underflow, 1);
    end
    de = 1'b0; tick();
    check("early_sticky", underflow, 1);
    check("early_blank_pix", pix_data, 0);
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
    check("early_cnt", underflow_cnt, 4);
`endif
    // restart with two reads in flight
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    check("rs_ready", host_ready, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("rs_pix", pix_data, 0);
    repeat (5) tick();
    check("rs_fill_addr", mem_addr, 3);
    de = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rs_pix_seq", pix_data, 'h10 + j);
    end
    de = 1'b0;
    // async reset mid-fill
    tick(); frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0; #1;
    check("ar_pix", pix_data, 0);
    check("ar_underflow", underflow, 0);
    check("ar_mem_addr", mem_addr, 0);
    check("ar_mem_we", mem_we, 0);
    check("ar_mem_wdata", mem_wdata, 0);
    check("ar_ready", host_ready, 0);
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
    check("ar_cnt", underflow_cnt, 0);
`endif
    tick(); rst_n = 1'b1; #1;
    check("ar_idle_ready", host_ready, 1);
    de = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("ar_no_stale", pix_data, 0);
      check("ar_empty_underflow", underflow, 1);
      check("ar_idle_addr", mem_addr, 0);
      check("ar_idle_we", mem_we, 0);
    end
    de = 1'b0;
`ifdef VGA_ARB_UNDERFLOW_CNT_EN
    check("ar_cnt_after", underflow_cnt, 3);
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
